// File: rtl/wb_uart_master_pkg.sv
// Shared types and wire-protocol constants for the UART-driven Wishbone initiator.
package wb_uart_master_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    BUS  = 3'd3,
    RESP = 3'd4
  } state_e;

  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;
  localparam logic [7:0] ST_OK  = 8'h06;
  localparam logic [7:0] ST_ERR = 8'h15;

endpackage

// File: rtl/wb_uart_master.sv
// Byte-stream command parser that runs one Wishbone classic cycle per frame
// and streams back a status byte plus read data.
module wb_uart_master
  import wb_uart_master_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int BUS_TIMEOUT = 255,
  parameter int RX_GAP      = 65535
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      i_rx_dat,
  input  logic            i_rx_vld,
  output logic [7:0]      o_tx_dat,
  output logic            o_tx_vld,
  input  logic            i_tx_rdy,
  output logic [AW-1:0]   o_wb_adr,
  output logic [DW/8-1:0] o_wb_sel,
  output logic            o_wb_we,
  output logic [DW-1:0]   o_wb_dat,
  input  logic [DW-1:0]   i_wb_dat,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  input  logic            i_wb_ack,
  input  logic            i_wb_err,
  output logic            o_busy,
  output logic            o_ovf
);

  localparam int GW = $clog2(RX_GAP + 1);
  localparam int TW = $clog2(BUS_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [AW-1:0]     adr_q, adr_d;
  logic [DW-1:0]     dat_q, dat_d;
  logic [DW-1:0]     rdat_q, rdat_d;
  logic [7:0]        st_q, st_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [2:0]        txi_q, txi_d;
  logic              cyc_q, cyc_d;
  logic [DW/8-1:0]   sel_q, sel_d;
  logic              wbwe_q, wbwe_d;
  logic [AW-1:0]     wadr_q, wadr_d;
  logic [DW-1:0]     wdat_q, wdat_d;
  logic              txv_q, txv_d;
  logic [7:0]        txd_q, txd_d;
  logic              ovf_q, ovf_d;
  logic [2:0]        tx_last;

  // Reads that completed OK carry 4 data bytes after the status byte.
  assign tx_last = (st_q == ST_OK && !we_q) ? 3'd4 : 3'd0;

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rdat_d  = rdat_q;
    st_d    = st_q;
    bcnt_d  = bcnt_q;
    gap_d   = gap_q;
    tmo_d   = tmo_q;
    txi_d   = txi_q;
    cyc_d   = cyc_q;
    sel_d   = sel_q;
    wbwe_d  = wbwe_q;
    wadr_d  = wadr_q;
    wdat_d  = wdat_q;
    txv_d   = txv_q;
    txd_d   = txd_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (i_rx_vld && (i_rx_dat == CMD_WR || i_rx_dat == CMD_RD)) begin
          state_d = ADDR;
          we_d    = (i_rx_dat == CMD_WR);
          bcnt_d  = '0;
          gap_d   = '0;
        end
      end

      ADDR, DATA: begin
        if (i_rx_vld) begin
          gap_d  = '0;
          bcnt_d = bcnt_q + 2'd1;
          if (state_q == ADDR) adr_d = {adr_q[AW-9:0], i_rx_dat};
          else                 dat_d = {dat_q[DW-9:0], i_rx_dat};
          if (bcnt_q == 2'd3) begin
            if (state_q == ADDR && we_q) begin
              state_d = DATA;
            end else begin
              state_d = BUS;
              cyc_d   = 1'b1;
              sel_d   = '1;
              wbwe_d  = we_q;
              wadr_d  = adr_d;
              wdat_d  = dat_d;
              tmo_d   = '0;
            end
          end
        end else if (gap_q == GW'(RX_GAP - 1)) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      BUS: begin
        if (i_wb_ack || i_wb_err || tmo_q == TW'(BUS_TIMEOUT - 1)) begin
          // err wins over a simultaneous ack; a timeout reports as err too.
          st_d = (i_wb_ack && !i_wb_err) ? ST_OK : ST_ERR;
          if (i_wb_ack && !i_wb_err && !we_q) rdat_d = i_wb_dat;
          cyc_d   = 1'b0;
          sel_d   = '0;
          wbwe_d  = 1'b0;
          state_d = RESP;
          txv_d   = 1'b1;
          txd_d   = st_d;
          txi_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      RESP: begin
        if (txv_q && i_tx_rdy) begin
          if (txi_q == tx_last) begin
            txv_d   = 1'b0;
            state_d = IDLE;
          end else begin
            txi_d = txi_q + 3'd1;
            case (txi_q)
              3'd0:    txd_d = rdat_q[31:24];
              3'd1:    txd_d = rdat_q[23:16];
              3'd2:    txd_d = rdat_q[15:8];
              default: txd_d = rdat_q[7:0];
            endcase
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if (i_rx_vld && (state_q == BUS || state_q == RESP)) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      rdat_q  <= '0;
      st_q    <= '0;
      bcnt_q  <= '0;
      gap_q   <= '0;
      tmo_q   <= '0;
      txi_q   <= '0;
      cyc_q   <= 1'b0;
      sel_q   <= '0;
      wbwe_q  <= 1'b0;
      wadr_q  <= '0;
      wdat_q  <= '0;
      txv_q   <= 1'b0;
      txd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rdat_q  <= rdat_d;
      st_q    <= st_d;
      bcnt_q  <= bcnt_d;
      gap_q   <= gap_d;
      tmo_q   <= tmo_d;
      txi_q   <= txi_d;
      cyc_q   <= cyc_d;
      sel_q   <= sel_d;
      wbwe_q  <= wbwe_d;
      wadr_q  <= wadr_d;
      wdat_q  <= wdat_d;
      txv_q   <= txv_d;
      txd_q   <= txd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_wb_cyc = cyc_q;
  assign o_wb_stb = cyc_q;
  assign o_wb_sel = sel_q;
  assign o_wb_we  = wbwe_q;
  assign o_wb_adr = wadr_q;
  assign o_wb_dat = wdat_q;
  assign o_tx_vld = txv_q;
  assign o_tx_dat = txd_q;
  assign o_busy   = (state_q != IDLE);
  assign o_ovf    = ovf_q;

endmodule

// File: tb/tb_wb_uart_master.sv
// Bench for wb_uart_master: table vectors, hand-written corner sequences and
// randomized frames against a frame-level reference model.
module tb_wb_uart_master;
  import wb_uart_master_pkg::*;

  localparam int BT = 16;
  localparam int RG = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  i_rx_dat = 8'h00;
  logic        i_rx_vld = 1'b0;
  logic [7:0]  o_tx_dat;
  logic        o_tx_vld;
  logic        i_tx_rdy = 1'b0;
  logic [31:0] o_wb_adr;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we;
  logic [31:0] o_wb_dat;
  logic [31:0] i_wb_dat;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        i_wb_ack = 1'b0;
  logic        i_wb_err = 1'b0;
  logic        o_busy;
  logic        o_ovf;

  always #5 clk = ~clk;

  wb_uart_master #(.AW(32), .DW(32), .BUS_TIMEOUT(BT), .RX_GAP(RG)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_rx_dat(i_rx_dat), .i_rx_vld(i_rx_vld),
    .o_tx_dat(o_tx_dat), .o_tx_vld(o_tx_vld), .i_tx_rdy(i_tx_rdy),
    .o_wb_adr(o_wb_adr), .o_wb_sel(o_wb_sel), .o_wb_we(o_wb_we),
    .o_wb_dat(o_wb_dat), .i_wb_dat(i_wb_dat),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
    .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
    .o_busy(o_busy), .o_ovf(o_ovf)
  );

  // slave modes: 0 ack, 1 err, 2 silent, 3 ack+err, 4 silent then late ack
  typedef struct {
    bit          we;
    logic [31:0] adr, dat, rd;
    int          mode, lat, rdym;
    int          n;
    logic [39:0] exp;
    int          stbn;
  } vec_t;

  int          checks = 0, errors = 0;
  int          smode = 0, slat = 1, rdym = 0, scnt = 0, unstable = 0;
  bit          hold = 1'b0, pcyc = 1'b0;
  logic [31:0] srd = 32'h0;
  logic [31:0] b_adr[$], b_dat[$];
  logic        b_we[$];
  logic [3:0]  b_sel[$];
  int          b_len[$];
  logic [7:0]  txq[$];
  vec_t        tbl[7];

  assign i_wb_dat = srd;

  // Everything set here is stable until the next posedge, so handshakes and
  // bus activity are recorded exactly as the DUT will sample them.
  always @(negedge clk) begin
    if (hold)           i_tx_rdy = 1'b0;
    else if (rdym == 0) i_tx_rdy = 1'b1;
    else if (rdym == 1) i_tx_rdy = ~i_tx_rdy;
    else                i_tx_rdy = 1'($urandom_range(0, 1));
    if (o_tx_vld && i_tx_rdy) txq.push_back(o_tx_dat);
    if (o_wb_cyc) begin
      if (!pcyc) begin
        b_adr.push_back(o_wb_adr); b_dat.push_back(o_wb_dat);
        b_we.push_back(o_wb_we);   b_sel.push_back(o_wb_sel);
        b_len.push_back(1);
      end else begin
        b_len[b_len.size()-1] += 1;
        if (o_wb_adr !== b_adr[b_adr.size()-1] || o_wb_dat !== b_dat[b_dat.size()-1] ||
            o_wb_we !== b_we[b_we.size()-1] || o_wb_sel !== b_sel[b_sel.size()-1] || !o_wb_stb)
          unstable++;
      end
    end
    i_wb_ack = 1'b0;
    i_wb_err = 1'b0;
    if (o_wb_cyc) begin
      scnt++;
      if (scnt >= slat) begin
        case (smode)
          0: i_wb_ack = 1'b1;
          1: i_wb_err = 1'b1;
          3: begin i_wb_ack = 1'b1; i_wb_err = 1'b1; end
          default: ;
        endcase
      end
    end else begin
      if (smode == 4 && scnt != 0) i_wb_ack = 1'b1;
      scnt = 0;
    end
    pcyc = o_wb_cyc;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    i_rx_vld = 1'b1;
    i_rx_dat = b;
    @(negedge clk);
    i_rx_vld = 1'b0;
  endtask

  task automatic clear_logs();
    txq.delete(); b_adr.delete(); b_dat.delete(); b_we.delete();
    b_sel.delete(); b_len.delete(); unstable = 0;
  endtask

  function automatic vec_t mk(bit we, logic [31:0] adr, logic [31:0] dat, logic [31:0] rd,
                              int mode, int lat, int rm, int n, logic [39:0] exp, int stbn);
    vec_t v;
    v.we = we; v.adr = adr; v.dat = dat; v.rd = rd; v.mode = mode; v.lat = lat;
    v.rdym = rm; v.n = n; v.exp = exp; v.stbn = stbn;
    return v;
  endfunction

  // Frame-level model: a clean ack is OK, anything else is an error status;
  // only an OK read returns the four data bytes.
  function automatic vec_t model(bit we, logic [31:0] adr, logic [31:0] dat, logic [31:0] rd,
                                 int mode, int lat, int rm);
    vec_t v;
    bit ok = (mode == 0);
    v = mk(we, adr, dat, rd, mode, lat, rm, 1, 40'h0, lat);
    v.n    = (ok && !we) ? 5 : 1;
    v.exp  = {ok ? ST_OK : ST_ERR, (ok && !we) ? rd : 32'h0};
    v.stbn = (mode == 2 || mode == 4) ? BT : lat;
    return v;
  endfunction

  task automatic run_frame(input vec_t v, input int gapmax, input bit inj);
    int t;
    logic [39:0] e;
    clear_logs();
    smode = v.mode; slat = v.lat; srd = v.rd; rdym = v.rdym;
    hold = inj;
    send_byte(v.we ? CMD_WR : CMD_RD);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, gapmax)) @(negedge clk);
      send_byte(v.adr[31-8*i -: 8]);
    end
    if (v.we)
      for (int i = 0; i < 4; i++) begin
        repeat ($urandom_range(0, gapmax)) @(negedge clk);
        send_byte(v.dat[31-8*i -: 8]);
      end
    if (v.lat == 1 && (v.mode == 0 || v.mode == 1 || v.mode == 3)) begin
      chk("lat_stb", o_wb_stb, 1);
      @(negedge clk);
      chk("lat_txvld", o_tx_vld, 1);
    end
    if (inj) begin
      t = 0;
      while (!o_tx_vld && t < 100) begin @(negedge clk); t++; end
      send_byte(8'h57);
      chk("ovf_set", o_ovf, 1);
      chk("ovf_still_resp", o_busy, 1);
      hold = 1'b0;
    end
    t = 0;
    while ((txq.size() < v.n || o_busy) && t < 3000) begin @(negedge clk); t++; end
    chk("resp_timeout", (t >= 3000), 0);
    repeat (3) @(negedge clk);
    chk("tx_count", txq.size(), v.n);
    e = v.exp;
    for (int i = 0; i < v.n && i < txq.size(); i++) begin
      chk($sformatf("tx_byte%0d", i), txq[i], e[39:32]);
      e = e << 8;
    end
    chk("bus_cycles", b_len.size(), 1);
    if (b_len.size() > 0) begin
      chk("wb_adr", b_adr[0], v.adr);
      chk("wb_we", b_we[0], v.we);
      chk("wb_sel", b_sel[0], 4'hF);
      chk("stb_len", b_len[0], v.stbn);
      if (v.we) chk("wb_dat", b_dat[0], v.dat);
    end
    chk("bus_stable", unstable, 0);
  endtask

  initial begin
    tbl[0] = mk(1, 32'h0100_0004, 32'hDEAD_BEEF, 32'h0, 0, 2, 0, 1, {ST_OK, 32'h0}, 2);
    tbl[1] = mk(0, 32'h0200_0000, 32'h0, 32'h1234_5678, 0, 1, 1, 5, {ST_OK, 32'h1234_5678}, 1);
    tbl[2] = mk(0, 32'h0000_0010, 32'h0, 32'hFFFF_0000, 1, 3, 0, 1, {ST_ERR, 32'h0}, 3);
    tbl[3] = mk(1, 32'h0000_0020, 32'h1122_3344, 32'h0, 1, 1, 2, 1, {ST_ERR, 32'h0}, 1);
    tbl[4] = mk(0, 32'h0000_0030, 32'h0, 32'hA5A5_A5A5, 2, 1, 0, 1, {ST_ERR, 32'h0}, BT);
    tbl[5] = mk(0, 32'h0000_0040, 32'h0, 32'h5A5A_5A5A, 4, 1, 1, 1, {ST_ERR, 32'h0}, BT);
    tbl[6] = mk(0, 32'h0000_0050, 32'h0, 32'h8765_4321, 3, 2, 0, 1, {ST_ERR, 32'h0}, 2);

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cyc", o_wb_cyc, 0);
    chk("rst_stb", o_wb_stb, 0);
    chk("rst_we", o_wb_we, 0);
    chk("rst_adr", o_wb_adr, 0);
    chk("rst_sel", o_wb_sel, 0);
    chk("rst_dat", o_wb_dat, 0);
    chk("rst_txvld", o_tx_vld, 0);
    chk("rst_txdat", o_tx_dat, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_ovf", o_ovf, 0);
    rst_n = 1'b1;

    send_byte(8'hAA);
    @(negedge clk);
    chk("garbage_busy", o_busy, 0);
    chk("garbage_ovf", o_ovf, 0);

    for (int i = 0; i < 7; i++) run_frame(tbl[i], 0, 1'b0);

    // Stalled frame is discarded once the inter-byte gap expires.
    clear_logs();
    send_byte(CMD_RD);
    send_byte(8'h01);
    repeat (10) @(negedge clk);
    chk("gap_busy", o_busy, 0);
    chk("gap_no_cycle", b_len.size(), 0);
    run_frame(mk(0, 32'h0, 32'h0, 32'h0BAD_F00D, 0, 1, 0, 5, {ST_OK, 32'h0BAD_F00D}, 1), 0, 1'b0);

    chk("ovf_before", o_ovf, 0);
    run_frame(mk(0, 32'h0000_1000, 32'h0, 32'hC0DE_1234, 0, 1, 0, 5, {ST_OK, 32'hC0DE_1234}, 1), 0, 1'b1);
    chk("ovf_sticky", o_ovf, 1);

    for (int k = 0; k < 25; k++) begin
      int md;
      md = $urandom_range(0, 9);
      md = (md < 5) ? 0 : (md < 7) ? 1 : (md < 8) ? 3 : (md < 9) ? 2 : 4;
      run_frame(model(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                      md, $urandom_range(1, 4), $urandom_range(0, 2)), 4, 1'b0);
    end

    // Reset while a bus cycle is outstanding.
    clear_logs();
    smode = 2; rdym = 0;
    send_byte(CMD_RD);
    for (int i = 0; i < 4; i++) send_byte(8'h00);
    repeat (3) @(negedge clk);
    chk("midbus_stb", o_wb_stb, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_cyc", o_wb_cyc, 0);
    chk("midrst_stb", o_wb_stb, 0);
    chk("midrst_txvld", o_tx_vld, 0);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_ovf", o_ovf, 0);
    rst_n = 1'b1;
    run_frame(mk(1, 32'h0000_0100, 32'hCAFE_F00D, 32'h0, 0, 2, 0, 1, {ST_OK, 32'h0}, 2), 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule
